pair_uart_printer: RTL and testbench

//  Consumes the (lhs, rhs) ASCII character pairs from the transformer stage and prints them on a UART TX line.

---
 rtl/pair_uart_printer.sv | 119 +++++++++++
 tb/tb_pair_uart_printer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_uart_printer.sv
// pair_uart_printer: prints (lhs, rhs) character pairs on a UART TX line, CR/LF after each last pair.
// Define PRINTER_PARITY_EN to insert an even-parity bit between data and stop.
module pair_uart_printer #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_lhs,
  input  logic [7:0] in_rhs,
  input  logic       in_last,
  output logic       tx,
  output logic       busy,
  output logic       line_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, LHS, RHS, CR, LF} p_state_t;
`ifdef PRINTER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, START, DATA, PARITY, STOP} s_state_t;
`else
  typedef enum logic [2:0] {S_IDLE, START, DATA, STOP} s_state_t;
`endif
  logic [16:0] mem [FIFO_DEPTH];
  logic [16:0] hold;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, empty, push, pop;
  p_state_t p_state, p_next;
  s_state_t s_state, s_next;
  logic [15:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh, cur_byte;
  logic start, bit_end, byte_done;
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign in_ready = !full;
  assign pop = p_state == IDLE && !empty;
  // a pop frees a slot in the same edge, so a full FIFO still takes a push then
  assign push = in_valid && (!full || pop);
  assign busy = !empty || p_state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_last, in_lhs, in_rhs};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold <= mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (rst) p_state <= IDLE;
    else p_state <= p_next;
  always_comb begin
    p_next = p_state;
    case (p_state)
      IDLE: p_next = empty ? IDLE : LHS;
      LHS: p_next = byte_done ? RHS : LHS;
      RHS: p_next = byte_done ? (hold[16] ? CR : IDLE) : RHS;
      CR: p_next = byte_done ? LF : CR;
      LF: p_next = byte_done ? IDLE : LF;
      default: p_next = IDLE;
    endcase
  end
  assign line_done = p_state == LF && byte_done;
  assign cur_byte = p_state == LHS ? hold[15:8] : p_state == RHS ? hold[7:0] : p_state == CR ? 8'h0D : 8'h0A;
  assign start = p_state != IDLE && s_state == S_IDLE;
  assign bit_end = cnt == '0;
  assign byte_done = s_state == STOP && bit_end;
  always_ff @(posedge clk)
    if (rst) s_state <= S_IDLE;
    else s_state <= s_next;
  always_comb begin
    s_next = s_state;
    case (s_state)
      S_IDLE: s_next = start ? START : S_IDLE;
      START: s_next = bit_end ? DATA : START;
`ifdef PRINTER_PARITY_EN
      DATA: s_next = bit_end && idx == 3'd7 ? PARITY : DATA;
      PARITY: s_next = bit_end ? STOP : PARITY;
`else
      DATA: s_next = bit_end && idx == 3'd7 ? STOP : DATA;
`endif
      STOP: s_next = bit_end ? S_IDLE : STOP;
      default: s_next = S_IDLE;
    endcase
  end
  always_comb begin
    tx = 1'b1;
    if (s_state == START) tx = 1'b0;
    if (s_state == DATA) tx = sh[idx];
`ifdef PRINTER_PARITY_EN
    if (s_state == PARITY) tx = ^sh;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else if (start) begin
      cnt <= 16'(CLKS_PER_BIT - 1);
      idx <= '0;
      sh <= cur_byte;
    end else if (s_state != S_IDLE) begin
      cnt <= bit_end ? 16'(CLKS_PER_BIT - 1) : cnt - 16'd1;
      if (s_state == DATA && bit_end) idx <= idx + 3'd1;
    end
  end
endmodule

// File: tb/tb_pair_uart_printer.sv
// tb_pair_uart_printer: table-driven check of pair printing, FIFO backpressure and reset abort.
module tb_pair_uart_printer;
  localparam int CPB = 4;
`ifdef PRINTER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_lhs = '0, in_rhs = '0;
  logic in_ready, tx, busy, line_done;
  pair_uart_printer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_lhs(in_lhs),
    .in_rhs(in_rhs), .in_last(in_last), .tx(tx), .busy(busy), .line_done(line_done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction
  typedef struct {
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic last;
    int nb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[18];
  logic [7:0] rx_q[$];
  int st_q[$];
  logic par_q[$];
  bit mon_active = 0;
  int ld_cnt = 0, ld_cyc = -1, bz_last = -1;
  initial begin
    int pos;
    logic cur;
    logic [NB-1:0] fr;
    pos = 0;
    cur = 1'b1;
    fr = '0;
    forever begin
      @(negedge clk);
      if (rst) mon_active = 0;
      else begin
        if (!mon_active && tx == 1'b0) begin
          mon_active = 1;
          pos = 0;
          st_q.push_back(cyc);
        end
        if (mon_active) begin
          if (pos % CPB == 0) begin
            cur = tx;
            fr[pos/CPB] = tx;
          end else chk("bit_hold", tx, cur);
          if (pos == FRAME - 1) begin
            chk("start_bit", fr[0], 0);
            chk("stop_bit", fr[NB-1], 1);
            rx_q.push_back(fr[8:1]);
            par_q.push_back(fr[NB-2]);
            mon_active = 0;
          end
          pos++;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (line_done) begin
      ld_cnt++;
      ld_cyc = cyc;
    end
    if (busy) bz_last = cyc;
  end
  task automatic push(input int i, output int waited);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("push_ready", in_ready, 1);
    in_valid = 1'b1;
    in_lhs = tbl[i].lhs;
    in_rhs = tbl[i].rhs;
    in_last = tbl[i].last;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || mon_active) && t < 5000);
    chk("idle_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (st_q.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_timeout", st_q.size() >= n, 1);
  endtask
  task automatic wait_cyc(input int c);
    int t;
    t = 0;
    while (cyc < c && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("cycle_reach", cyc, c);
  endtask
  task automatic check_out(input int base, input int first, input int last_i);
    int k, total;
    k = base;
    total = 0;
    for (int i = first; i <= last_i; i++)
      for (int j = 0; j < tbl[i].nb; j++) begin
        chk("byte", k < rx_q.size() ? int'(rx_q[k]) : -1, int'(tbl[i].exp[31-8*j -: 8]));
        k++;
        total++;
      end
    chk("byte_count", rx_q.size() - base, total);
  endtask
  initial begin
    int base, sb, ld0, w;
    tbl[0] = '{8'h41, 8'h62, 1'b1, 4, 32'h41620D0A};
    tbl[1] = '{8'h78, 8'h79, 1'b0, 2, 32'h78790000};
    tbl[2] = '{8'h70, 8'h71, 1'b0, 2, 32'h70710000};
    tbl[3] = '{8'h48, 8'h69, 1'b1, 4, 32'h48690D0A};
    tbl[4] = '{8'h31, 8'h32, 1'b0, 2, 32'h31320000};
    tbl[5] = '{8'h33, 8'h34, 1'b0, 2, 32'h33340000};
    tbl[6] = '{8'h35, 8'h36, 1'b0, 2, 32'h35360000};
    tbl[7] = '{8'h37, 8'h38, 1'b0, 2, 32'h37380000};
    tbl[8] = '{8'h39, 8'h30, 1'b0, 2, 32'h39300000};
    tbl[9] = '{8'h5A, 8'h7A, 1'b1, 4, 32'h5A7A0D0A};
    tbl[10] = '{8'h4F, 8'h4B, 1'b1, 4, 32'h4F4B0D0A};
    tbl[11] = '{8'h61, 8'h62, 1'b0, 2, 32'h61620000};
    tbl[12] = '{8'h63, 8'h64, 1'b0, 2, 32'h63640000};
    tbl[13] = '{8'h65, 8'h66, 1'b0, 2, 32'h65660000};
    tbl[14] = '{8'h67, 8'h68, 1'b0, 2, 32'h67680000};
    tbl[15] = '{8'h69, 8'h6A, 1'b0, 2, 32'h696A0000};
    tbl[16] = '{8'h6B, 8'h6C, 1'b1, 4, 32'h6B6C0D0A};
    tbl[17] = '{8'h41, 8'h43, 1'b1, 4, 32'h41430D0A};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_line_done", line_done, 0);
    chk("reset_in_ready", in_ready, 1);
    // single pair with line end
    base = rx_q.size(); sb = st_q.size(); ld0 = ld_cnt;
    push(0, w);
    wait_idle();
    check_out(base, 0, 0);
    for (int j = 1; j < 4; j++) chk("byte_spacing", st_q[sb+j] - st_q[sb+j-1], FRAME + 1);
    chk("line_done_count", ld_cnt - ld0, 1);
    chk("line_done_cycle", ld_cyc, st_q[sb+3] + FRAME - 1);
    chk("busy_fall", bz_last, ld_cyc);
    // three back-to-back pairs
    base = rx_q.size(); sb = st_q.size(); ld0 = ld_cnt;
    for (int i = 1; i <= 3; i++) begin
      push(i, w);
      chk("no_stall", w, 0);
    end
    wait_idle();
    check_out(base, 1, 3);
    chk("pair_gap", st_q[sb+2] - st_q[sb+1], FRAME + 2);
    chk("line_done_count2", ld_cnt - ld0, 1);
    // overfill: the sixth push must wait for a free slot
    base = rx_q.size();
    for (int i = 4; i <= 8; i++) push(i, w);
    @(negedge clk);
    chk("full_ready", in_ready, 0);
    push(9, w);
    chk("blocked_push", w > 0, 1);
    wait_idle();
    check_out(base, 4, 9);
    // reset in the middle of the rhs data bits
    base = rx_q.size(); sb = st_q.size(); ld0 = ld_cnt;
    push(0, w);
    wait_frames(sb + 2);
    wait_cyc(st_q[sb+1] + 12);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_line_done", line_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_line_done", ld_cnt - ld0, 0);
    chk("abort_bytes", rx_q.size() - base, 1);
    chk("abort_first_byte", base < rx_q.size() ? int'(rx_q[base]) : -1, 8'h41);
    push(10, w);
    wait_idle();
    check_out(base + 1, 10, 10);
    chk("after_abort_line_done", ld_cnt - ld0, 1);
    // push lands on the same edge as a pop while full
    base = rx_q.size(); sb = st_q.size();
    for (int i = 11; i <= 15; i++) push(i, w);
    @(negedge clk);
    chk("full_ready2", in_ready, 0);
    wait_frames(sb + 2);
    wait_cyc(st_q[sb+1] + FRAME);
    chk("ready_at_pop", in_ready, 0);
    in_valid = 1'b1;
    in_lhs = tbl[16].lhs;
    in_rhs = tbl[16].rhs;
    in_last = tbl[16].last;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_pushpop", in_ready, 0);
    wait_idle();
    check_out(base, 11, 16);
`ifdef PRINTER_PARITY_EN
    base = rx_q.size(); sb = st_q.size(); w = par_q.size();
    push(17, w);
    w = par_q.size();
    wait_idle();
    check_out(base, 17, 17);
    chk("parity_41", par_q[base], 0);
    chk("parity_43", par_q[base+1], 1);
    chk("parity_frame", st_q[sb+1] - st_q[sb], 45);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
